// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator CPU: default widths, the
// instruction opcodes decoded from IR[7:5], and the phase encoding used by
// the controller that drives the datapath strobes.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 5;
    localparam int CPU_OPC_W  = 3;

    localparam logic [CPU_OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [CPU_OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [CPU_OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [CPU_OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [CPU_OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [CPU_OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [CPU_OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [CPU_OPC_W-1:0] OP_JMP = 3'b111;

    // Eight controller phases per instruction, in execution order.
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

endpackage

// File: rtl/risc_alu.sv
// -----------------------------------------------------------------------------
// risc_alu
// Purely combinational ALU. Opcodes that do not compute (HLT, SKZ, STO, JMP)
// pass the accumulator through so a stray ld_ac leaves AC unchanged.
// Ports:
//   opcode    in   3       instruction opcode from IR
//   ac        in   DATA_W  accumulator operand
//   mem_rdata in   DATA_W  memory operand
//   result    out  DATA_W  value offered to AC
// -----------------------------------------------------------------------------
module risc_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [CPU_OPC_W-1:0] opcode,
    input  logic [DATA_W-1:0]    ac,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    result
);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        result = ac;
        unique case (opcode)
            OP_ADD:  result = ac + mem_rdata;   // carry discarded
            OP_AND:  result = ac & mem_rdata;
            OP_XOR:  result = ac ^ mem_rdata;
            OP_LDA:  result = mem_rdata;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/risc_datapath.sv
// -----------------------------------------------------------------------------
// risc_datapath
// Register/ALU datapath of the accumulator CPU. Holds IR, PC, AC and a sticky
// halted flag, updated from the controller's per-phase strobes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sel                      mem_addr source: 1 = PC, 0 = IR address field
//   ld_ir, inc_pc, ld_pc     IR / PC update strobes (ld_pc beats inc_pc)
//   ld_ac                    AC <= ALU result
//   data_e                   write-data bus enable
//   halt                     stop request; sets sticky halted
//   mem_rdata                memory read data
//   mem_addr, mem_wdata      memory address and write data (AC)
//   mem_wdata_oe             follows data_e
//   opcode, zero             decode feedback to the controller
//   halted, ac_q             status / visibility
// -----------------------------------------------------------------------------
module risc_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int OPC_W  = CPU_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              ld_ac,
    input  logic              data_e,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    output logic [OPC_W-1:0]  opcode,
    output logic              zero,
    output logic              halted,
    output logic [DATA_W-1:0] ac_q
);

    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ac;
    logic              r_halted;
    logic [DATA_W-1:0] w_alu_result;
    logic [ADDR_W-1:0] w_ir_addr;

    assign w_ir_addr = r_ir[ADDR_W-1:0];

    risc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode    (r_ir[DATA_W-1 -: OPC_W]),
        .ac        (r_ac),
        .mem_rdata (mem_rdata),
        .result    (w_alu_result)
    );

    // The halt edge itself still commits the other strobes (so the PC
    // increment of the halting cycle lands); only later edges are frozen.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_ir     <= '0;
            r_pc     <= '0;
            r_ac     <= '0;
            r_halted <= 1'b0;
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (!r_halted) begin
                if (ld_ir) begin
                    r_ir <= mem_rdata;
                end
                if (ld_pc) begin
                    r_pc <= w_ir_addr;
                end else if (inc_pc) begin
                    r_pc <= r_pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                end
                if (ld_ac) begin
                    r_ac <= w_alu_result;
                end
            end
        end
    end

    assign mem_addr     = sel ? r_pc : w_ir_addr;
    assign mem_wdata    = r_ac;
    assign mem_wdata_oe = data_e;
    assign opcode       = r_ir[DATA_W-1 -: OPC_W];
    assign zero         = (r_ac == '0);
    assign halted       = r_halted;
    assign ac_q         = r_ac;

endmodule

// File: tb/tb_risc_datapath.sv
// -----------------------------------------------------------------------------
// tb_risc_datapath
// Directed checks of the datapath: reset, fetch/LDA, ALU operations, PC wrap
// and load-over-increment priority, store bus, and sticky halt.
// -----------------------------------------------------------------------------
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wdata_oe;
    logic [2:0] opcode;
    logic       zero;
    logic       halted;
    logic [7:0] ac_q;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    risc_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .ld_ir        (ld_ir),
        .inc_pc       (inc_pc),
        .ld_pc        (ld_pc),
        .ld_ac        (ld_ac),
        .data_e       (data_e),
        .halt         (halt),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .opcode       (opcode),
        .zero         (zero),
        .halted       (halted),
        .ac_q         (ac_q)
    );

    // Strobes must never be X at a sampling edge.
    always @(posedge clk) begin
        assert (!$isunknown({rst, sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}))
        else $error("FAIL strobe_x: unknown value on a strobe");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply the currently driven strobes on one edge, then clear them and
    // settle #1 past the edge before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic load_ir(input logic [7:0] value);
        mem_rdata = value;
        ld_ir     = 1'b1;
        tick();
    endtask

    task automatic load_ac(input logic [7:0] value);
        mem_rdata = value;
        ld_ac     = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b1; data_e = 1'b0; mem_rdata = 8'h00;
        ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0; ld_ac = 1'b0; halt = 1'b0;

        // Reset for two cycles, with strobes active to show rst overrides them.
        tick();
        mem_rdata = 8'hA5; ld_ir = 1'b1; inc_pc = 1'b1; ld_ac = 1'b1; halt = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_pc",     32'(mem_addr), 32'h00);
        check("rst_ac",     32'(ac_q),     32'h00);
        check("rst_zero",   32'(zero),     32'h1);
        check("rst_opcode", 32'(opcode),   32'h0);
        check("rst_halted", 32'(halted),   32'h0);
        check("rst_wdata",  32'(mem_wdata), 32'h00);

        // Fetch A3 (LDA, address 03), then operand 5C.
        load_ir(8'hA3);
        check("fetch_opcode", 32'(opcode), 32'h5);
        check("fetch_pc_addr", 32'(mem_addr), 32'h00);
        sel = 1'b0; #1;
        check("fetch_ir_addr", 32'(mem_addr), 32'h03);
        sel = 1'b1;
        load_ac(8'h5C);
        check("lda_ac",   32'(ac_q), 32'h5C);
        check("lda_zero", 32'(zero), 32'h0);

        // ALU operations starting from AC=F0.
        load_ac(8'hF0);
        load_ir(8'h40);                 // ADD
        load_ac(8'h20);
        check("add_wrap", 32'(ac_q), 32'h10);
        load_ir(8'h60);                 // AND
        load_ac(8'h0F);
        check("and_ac",   32'(ac_q), 32'h00);
        check("and_zero", 32'(zero), 32'h1);
        load_ir(8'h80);                 // XOR
        load_ac(8'hFF);
        check("xor_ac",   32'(ac_q), 32'hFF);
        check("xor_zero", 32'(zero), 32'h0);
        load_ir(8'hC0);                 // STO: ld_ac must leave AC alone
        load_ac(8'h12);
        check("sto_pass", 32'(ac_q), 32'hFF);

        // PC wrap: JMP to 1F, then increment.
        load_ir(8'hFF);
        ld_pc = 1'b1; tick();
        check("jmp_pc", 32'(mem_addr), 32'h1F);
        inc_pc = 1'b1; tick();
        check("pc_wrap", 32'(mem_addr), 32'h00);

        // ld_pc beats inc_pc.
        load_ir(8'hE7);
        ld_pc = 1'b1; inc_pc = 1'b1; tick();
        check("pc_prio", 32'(mem_addr), 32'h07);
        inc_pc = 1'b1; tick();
        check("pc_inc", 32'(mem_addr), 32'h08);

        // Store bus.
        load_ir(8'hA0);
        load_ac(8'h3C);
        data_e = 1'b1; #1;
        check("sto_wdata", 32'(mem_wdata),    32'h3C);
        check("sto_oe_on", 32'(mem_wdata_oe), 32'h1);
        data_e = 1'b0; #1;
        check("sto_oe_off", 32'(mem_wdata_oe), 32'h0);

        // Halt: PC=04, IR=00, then halt together with inc_pc.
        load_ir(8'h04);
        ld_pc = 1'b1; tick();
        load_ir(8'h00);
        check("halt_pre_pc", 32'(mem_addr), 32'h04);
        halt = 1'b1; inc_pc = 1'b1; tick();
        check("halt_pc",  32'(mem_addr), 32'h05);
        check("halt_set", 32'(halted),   32'h1);
        mem_rdata = 8'hA9; ld_ir = 1'b1; inc_pc = 1'b1; ld_ac = 1'b1; ld_pc = 1'b1;
        tick();
        check("halt_pc_hold", 32'(mem_addr), 32'h05);
        check("halt_ac_hold", 32'(ac_q),     32'h3C);
        check("halt_ir_hold", 32'(opcode),   32'h0);
        check("halt_sticky",  32'(halted),   32'h1);
        data_e = 1'b1; #1;
        check("halt_oe_live", 32'(mem_wdata_oe), 32'h1);
        data_e = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        check("halt_clr",    32'(halted),   32'h0);
        check("halt_rst_pc", 32'(mem_addr), 32'h00);
        check("halt_rst_ac", 32'(ac_q),     32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
